// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
// Owns the fetch PC of the MIPS core and drives the req/ack instruction
// memory port. Redirects (exception > branch > jump) retarget the PC and
// flush anything already fetched. Returned words go to an output register
// backed by a one-entry skid so a decode stall never drops an instruction.
// All outputs come straight from registers.

module pc_fetch_controller #(
    parameter int              N          = 32,
    parameter logic [N-1:0]    RESET_PC   = 32'h0040_0000,
    parameter logic [N-1:0]    EXC_VECTOR = 32'h8000_0180
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           exception,
    input  logic           branch_taken,
    input  logic [N-1:0]   branch_target,
    input  logic           jump,
    input  logic [N-1:0]   jump_target,
    output logic           imem_req,
    output logic [N-1:0]   imem_addr,
    input  logic           imem_ack,
    input  logic [31:0]    imem_rdata,
    output logic           instr_valid,
    output logic [31:0]    instr,
    output logic [N-1:0]   instr_pc,
    output logic [N-1:0]   pc_value
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'b100};

    // Registered state
    state_t         state_r;
    logic [N-1:0]   pc_r;
    logic [N-1:0]   addr_r;
    logic           req_r;
    logic           valid_r;
    logic [31:0]    instr_r;
    logic [N-1:0]   instr_pc_r;
    logic           skid_valid_r;
    logic [31:0]    skid_instr_r;
    logic [N-1:0]   skid_pc_r;

    // Next-state values
    state_t         state_next_s;
    logic [N-1:0]   pc_next_s;
    logic [N-1:0]   addr_next_s;
    logic           req_next_s;
    logic           valid_next_s;
    logic [31:0]    instr_next_s;
    logic [N-1:0]   instr_pc_next_s;
    logic           skid_valid_next_s;
    logic [31:0]    skid_instr_next_s;
    logic [N-1:0]   skid_pc_next_s;

    // Decoded events
    logic           redirect_s;
    logic [N-1:0]   target_raw_s;
    logic [N-1:0]   target_s;
    logic           consume_s;
    logic           ack_take_s;

    // Redirect selection by priority and word alignment of the target
    always_comb begin
        redirect_s   = exception | branch_taken | jump;
        target_raw_s = pc_r;
        if (exception) begin
            target_raw_s = EXC_VECTOR;
        end else if (branch_taken) begin
            target_raw_s = branch_target;
        end else if (jump) begin
            target_raw_s = jump_target;
        end else begin
            target_raw_s = pc_r;
        end
        target_s   = {target_raw_s[N-1:2], 2'b00};
        consume_s  = valid_r & ~stall;
        // An ack that coincides with a redirect belongs to the old stream
        ack_take_s = (state_r == REQ) & imem_ack & ~redirect_s;
    end

    // Output register / skid buffer movement and PC update
    always_comb begin
        pc_next_s         = pc_r;
        valid_next_s      = valid_r;
        instr_next_s      = instr_r;
        instr_pc_next_s   = instr_pc_r;
        skid_valid_next_s = skid_valid_r;
        skid_instr_next_s = skid_instr_r;
        skid_pc_next_s    = skid_pc_r;
        if (redirect_s) begin
            pc_next_s         = target_s;
            valid_next_s      = 1'b0;
            skid_valid_next_s = 1'b0;
        end else if (ack_take_s) begin
            pc_next_s = pc_r + PC_STEP;
            // A request only starts with the skid empty, so there is room
            if (!valid_r || consume_s) begin
                valid_next_s    = 1'b1;
                instr_next_s    = imem_rdata;
                instr_pc_next_s = pc_r;
            end else begin
                skid_valid_next_s = 1'b1;
                skid_instr_next_s = imem_rdata;
                skid_pc_next_s    = pc_r;
            end
        end else if (consume_s) begin
            if (skid_valid_r) begin
                instr_next_s      = skid_instr_r;
                instr_pc_next_s   = skid_pc_r;
                skid_valid_next_s = 1'b0;
            end else begin
                valid_next_s = 1'b0;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Fetch FSM next state and registered memory-port outputs
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                state_next_s = REQ;
            end
            REQ: begin
                if (redirect_s) begin
                    state_next_s = imem_ack ? REQ : DISCARD;
                end else if (imem_ack) begin
                    state_next_s = skid_valid_next_s ? HOLD : REQ;
                end else begin
                    state_next_s = REQ;
                end
            end
            HOLD: begin
                if (redirect_s || consume_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = HOLD;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = DISCARD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        req_next_s = (state_next_s == REQ) || (state_next_s == DISCARD);
        // DISCARD keeps presenting the stale address until its ack
        if (state_next_s == REQ) begin
            addr_next_s = pc_next_s;
        end else begin
            addr_next_s = addr_r;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            addr_r       <= RESET_PC;
            req_r        <= 1'b0;
            valid_r      <= 1'b0;
            instr_r      <= 32'h0000_0000;
            instr_pc_r   <= {N{1'b0}};
            skid_valid_r <= 1'b0;
            skid_instr_r <= 32'h0000_0000;
            skid_pc_r    <= {N{1'b0}};
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            addr_r       <= addr_next_s;
            req_r        <= req_next_s;
            valid_r      <= valid_next_s;
            instr_r      <= instr_next_s;
            instr_pc_r   <= instr_pc_next_s;
            skid_valid_r <= skid_valid_next_s;
            skid_instr_r <= skid_instr_next_s;
            skid_pc_r    <= skid_pc_next_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign pc_value    = pc_r;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller. A small memory model acks after
// a programmable number of wait cycles and returns addr ^ KEY as data.

module tb_pc_fetch_controller;

    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        exception;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_value;

    logic [3:0]  wait_cycles;
    logic [3:0]  wcnt;
    int          nvec;
    int          nerr;

    pc_fetch_controller dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .exception     (exception),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_value      (pc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: count wait cycles of the current request
    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) wcnt <= 4'd0;
        else wcnt <= wcnt + 4'd1;
    end
    assign imem_ack   = imem_req && (wcnt == wait_cycles);
    assign imem_rdata = imem_addr ^ KEY;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b want 0", imem_req); end
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        nvec++; if (pc_value !== 32'h0040_0000) begin nerr++; $display("FAIL reset_pc: got %h want 00400000", pc_value); end
        nvec++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin nerr++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        step();
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin nerr++; $display("FAIL stream_first: got req=%b addr=%h want 1/00400000", imem_req, imem_addr); end
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL stream_valid0: got %b want 0", instr_valid); end
        step();
        nvec++; if (imem_addr !== 32'h0040_0004) begin nerr++; $display("FAIL stream_addr1: got %h want 00400004", imem_addr); end
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0000) begin nerr++; $display("FAIL stream_out0: got v=%b pc=%h want 1/00400000", instr_valid, instr_pc); end
        nvec++; if (instr !== (32'h0040_0000 ^ KEY)) begin nerr++; $display("FAIL stream_instr0: got %h want %h", instr, 32'h0040_0000 ^ KEY); end
        step();
        nvec++; if (imem_addr !== 32'h0040_0008 || instr_pc !== 32'h0040_0004) begin nerr++; $display("FAIL stream_addr2: got addr=%h ipc=%h want 00400008/00400004", imem_addr, instr_pc); end
        nvec++; if (pc_value !== 32'h0040_0008) begin nerr++; $display("FAIL stream_pc: got %h want 00400008", pc_value); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL stall_req%0d: got %b want 0", i, imem_req); end
            nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0004) begin nerr++; $display("FAIL stall_hold%0d: got v=%b pc=%h want 1/00400004", i, instr_valid, instr_pc); end
        end
        nvec++; if (pc_value !== 32'h0040_000C) begin nerr++; $display("FAIL stall_pc: got %h want 0040000c", pc_value); end
        stall = 1'b0;
        step();
        nvec++; if (instr_pc !== 32'h0040_0008 || instr !== (32'h0040_0008 ^ KEY)) begin nerr++; $display("FAIL stall_skid: got pc=%h i=%h want 00400008", instr_pc, instr); end
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_000C) begin nerr++; $display("FAIL stall_resume: got req=%b addr=%h want 1/0040000c", imem_req, imem_addr); end
        step();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_000C) begin nerr++; $display("FAIL stall_next: got v=%b pc=%h want 1/0040000c", instr_valid, instr_pc); end
        nvec++; if (imem_addr !== 32'h0040_0010) begin nerr++; $display("FAIL stall_addr: got %h want 00400010", imem_addr); end
    endtask

    task automatic test_branch_discard();
        wait_cycles   = 4'd2;
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0100;
        step();
        branch_taken  = 1'b0;
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0010) begin nerr++; $display("FAIL br_stale: got req=%b addr=%h want 1/00400010", imem_req, imem_addr); end
        nvec++; if (instr_valid !== 1'b0 || pc_value !== 32'h0040_0100) begin nerr++; $display("FAIL br_flush: got v=%b pc=%h want 0/00400100", instr_valid, pc_value); end
        step();
        nvec++; if (imem_addr !== 32'h0040_0010 || instr_valid !== 1'b0) begin nerr++; $display("FAIL br_wait: got addr=%h v=%b want 00400010/0", imem_addr, instr_valid); end
        step();
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100 || instr_valid !== 1'b0) begin nerr++; $display("FAIL br_newreq: got req=%b addr=%h v=%b want 1/00400100/0", imem_req, imem_addr, instr_valid); end
        for (int i = 0; i < 2; i++) begin
            step();
            nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL br_novalid%0d: got %b want 0", i, instr_valid); end
        end
        step();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0100 || instr !== (32'h0040_0100 ^ KEY)) begin nerr++; $display("FAIL br_target: got v=%b pc=%h i=%h want 1/00400100", instr_valid, instr_pc, instr); end
        wait_cycles = 4'd0;
    endtask

    task automatic test_priority();
        exception     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0300;
        jump          = 1'b1;
        jump_target   = 32'h0040_0400;
        step();
        exception = 1'b0;
        nvec++; if (imem_addr !== 32'h8000_0180 || instr_valid !== 1'b0) begin nerr++; $display("FAIL prio_exc: got addr=%h v=%b want 80000180/0", imem_addr, instr_valid); end
        step();
        branch_taken = 1'b0;
        jump         = 1'b0;
        nvec++; if (imem_addr !== 32'h0040_0300) begin nerr++; $display("FAIL prio_br: got %h want 00400300", imem_addr); end
        step();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0300) begin nerr++; $display("FAIL prio_out: got v=%b pc=%h want 1/00400300", instr_valid, instr_pc); end
    endtask

    task automatic test_jump_align();
        jump        = 1'b1;
        jump_target = 32'h0040_0203;
        step();
        jump = 1'b0;
        nvec++; if (imem_addr !== 32'h0040_0200 || pc_value !== 32'h0040_0200) begin nerr++; $display("FAIL jmp_align: got addr=%h pc=%h want 00400200", imem_addr, pc_value); end
        step();
        nvec++; if (instr_pc !== 32'h0040_0200) begin nerr++; $display("FAIL jmp_out: got %h want 00400200", instr_pc); end
    endtask

    task automatic test_wrap();
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        nvec++; if (pc_value !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_set: got %h want fffffffc", pc_value); end
        step();
        nvec++; if (pc_value !== 32'h0000_0000 || imem_addr !== 32'h0000_0000) begin nerr++; $display("FAIL wrap_pc: got pc=%h addr=%h want 0/0", pc_value, imem_addr); end
        nvec++; if (instr_pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin nerr++; $display("FAIL wrap_out: got pc=%h v=%b want fffffffc/1", instr_pc, instr_valid); end
    endtask

    task automatic test_reset_mid_wait();
        wait_cycles = 4'd3;
        step();
        nvec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin nerr++; $display("FAIL rmw_pending: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        reset = 1'b1;
        step();
        nvec++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin nerr++; $display("FAIL rmw_idle: got req=%b v=%b want 0/0", imem_req, instr_valid); end
        nvec++; if (pc_value !== 32'h0040_0000) begin nerr++; $display("FAIL rmw_pc: got %h want 00400000", pc_value); end
        reset = 1'b0;
        wait_cycles = 4'd0;
    endtask

    initial begin
        nvec          = 0;
        nerr          = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        exception     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        wait_cycles   = 4'd0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_branch_discard();
        test_priority();
        test_jump_align();
        test_wrap();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pc_fetch_controller.md
# pc_fetch_controller

Sequences the 32-bit program counter and the instruction-memory fetch port of the MIPS core. It owns the fetch PC, issues request/acknowledge fetches, and applies exception, branch and jump redirects by priority. It buffers returned instructions behind a one-entry skid buffer so decode stalls never lose data. It sits between the instruction memory and the IF/ID stage.

## Interface
- N, 32, PC and address width
- RESET_PC, 32'h0040_0000, PC value after reset (4,194,304)
- EXC_VECTOR, 32'h8000_0180, exception redirect target
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  IF/ID cannot accept an instruction this cycle
- exception  in  1  redirect to EXC_VECTOR
- branch_taken  in  1  redirect to branch_target
- branch_target  in  N  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  N  jump/jr destination
- imem_req  out  1  fetch request
- imem_addr  out  N  fetch address, stable while imem_req=1
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc hold a live instruction
- instr  out  32  instruction to IF/ID
- instr_pc  out  N  address of instr
- pc_value  out  N  current fetch PC

## Operation
- Reset (sampled at the clk edge): pc_value=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, skid empty.
- Redirect = exception | branch_taken | jump. Priority: exception > branch_taken > jump. Target bits [1:0] are forced to 00.
- Consume: at any edge with instr_valid=1 and stall=0, the output register is consumed. The skid entry, if present, moves into the output register at that edge.
- States:
  - IDLE: imem_req=0. The next edge moves to REQ.
  - REQ: imem_req=1, imem_addr=pc_value, held until ack. On ack without redirect, the data (instr_pc=pc_value) goes to the output register if it is empty or being consumed this edge, otherwise to the skid. pc_value <= pc_value+4, wrapping modulo 2^N. Next state is HOLD if the skid is full after this edge, else REQ.
  - HOLD: imem_req=0. Moves to REQ at the edge where the skid drains.
  - DISCARD: imem_req=1 with the stale imem_addr until ack. The acked data is dropped. Then moves to REQ.
- Redirect handling, all cases: pc_value <= target, and instr_valid and the skid are flushed at that edge.
  - REQ without ack: go to DISCARD.
  - REQ with ack in the same cycle: data dropped, stay in REQ.
  - DISCARD: update the target, stay in DISCARD.
  - IDLE or HOLD: go to REQ.
- A new request starts only with the skid empty, so an ack always has space.
- Reset mid-request: the controller returns to IDLE immediately and stops driving the pending request. The memory must abort on reset.

## Timing
- imem_ack is sampled at the rising edge. A zero-wait memory (ack in the same cycle as req) gives 1 instruction per cycle with no stalls.
- The first request is issued 1 cycle after reset deasserts (IDLE→REQ).
- Fetch-to-instr_valid latency is 1 edge after the ack.
- Redirect penalty:
  - The first request to the target appears the cycle after the redirect edge.
  - The DISCARD case adds the remaining wait of the stale request.
- imem_addr is constant for the whole of each req-high interval.

## Test plan
- Reset release with zero-wait memory:
  - imem_addr sequence 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
  - instr_pc follows one cycle later.
- Stall held for 3 cycles with instr_valid=1:
  - The skid fills, the state goes to HOLD, imem_req=0.
  - On release, instructions emerge in order with no loss or duplication.
- branch_taken=1 with branch_target=0x00400100 while a 2-wait fetch of 0x00400010 is pending:
  - The stale ack is dropped, the next imem_addr=0x00400100, and instr_valid stays 0 until that ack.
- exception=1, branch_taken=1 and jump=1 in the same cycle:
  - The next imem_addr is 0x80000180.
- jump_target=0x00400203: the fetch address is 0x00400200.
- pc_value=0xFFFFFFFC with an ack: pc_value wraps to 0x00000000.
- reset asserted mid-wait: the next cycle shows imem_req=0, instr_valid=0, pc_value=0x00400000.
